// File: rtl/reorder_buffer_commit_if.sv
// Dispatch, writeback and retire buses of reorder_buffer_commit.
// slave = the reorder buffer; master = issue stage / CDB / predictor side.
interface reorder_buffer_commit_if #(
  parameter int IDX_W = 4
);
  logic             issue_valid;
  logic [31:0]      issue_pc;
  logic [5:0]       issue_op;
  logic [2:0]       issue_op_type;
  logic             issue_pred;
  logic [31:0]      issue_imm;
  logic [4:0]       issue_rd;
  logic [IDX_W-1:0] issue_tag;
  logic             rob_full;

  logic             wb_valid;
  logic [IDX_W-1:0] wb_tag;
  logic [31:0]      wb_value;
  logic [31:0]      wb_target;

  logic             rob_commit;
  logic [31:0]      rob_pc_commit;
  logic [5:0]       rob_op_commit;
  logic [2:0]       rob_op_type;
  logic [31:0]      rob_result;
  logic [31:0]      rob_pc_result;
  logic             roll_back;
  logic [4:0]       commit_rd;
  logic [31:0]      commit_value;

  modport master (
    output issue_valid, issue_pc, issue_op, issue_op_type, issue_pred, issue_imm, issue_rd,
           wb_valid, wb_tag, wb_value, wb_target,
    input  issue_tag, rob_full, rob_commit, rob_pc_commit, rob_op_commit, rob_op_type,
           rob_result, rob_pc_result, roll_back, commit_rd, commit_value
  );

  modport slave (
    input  issue_valid, issue_pc, issue_op, issue_op_type, issue_pred, issue_imm, issue_rd,
           wb_valid, wb_tag, wb_value, wb_target,
    output issue_tag, rob_full, rob_commit, rob_pc_commit, rob_op_commit, rob_op_type,
           rob_result, rob_pc_result, roll_back, commit_rd, commit_value
  );
endinterface

// File: rtl/reorder_buffer_commit.sv
// In-order retirement queue driving the branch predictor's commit port.
// Optional macro ROB_STATS_EN adds commit / misprediction counters.
module reorder_buffer_commit #(
  parameter int         ROB_DEPTH = 16,
  parameter int         IDX_W     = 4,
  parameter logic [5:0] OP_JALR   = 6'd3,  // opcode enum value of JALR
  parameter logic [2:0] OP_TYPE_B = 3'd3   // op class value of B-type branches
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic rdy_in,
  reorder_buffer_commit_if.slave rob
`ifdef ROB_STATS_EN
  ,
  output logic [31:0] stat_commits,
  output logic [31:0] stat_mispredicts
`endif
);
  typedef enum logic {RUN, FLUSH} state_t;
  localparam logic [IDX_W:0] DEPTH_CNT = (IDX_W+1)'(ROB_DEPTH);

  state_t               state;
  logic [IDX_W-1:0]     head, tail;
  logic [IDX_W:0]       count;
  logic [ROB_DEPTH-1:0] ready;

  logic [31:0] pc_q      [ROB_DEPTH];
  logic [5:0]  op_q      [ROB_DEPTH];
  logic [2:0]  op_type_q [ROB_DEPTH];
  logic        pred_q    [ROB_DEPTH];
  logic [31:0] imm_q     [ROB_DEPTH];
  logic [4:0]  rd_q      [ROB_DEPTH];
  logic [31:0] value_q   [ROB_DEPTH];
  logic [31:0] target_q  [ROB_DEPTH];

  logic             full, do_dispatch, wb_hit, do_retire;
  logic             head_is_b, head_taken, mispredict;
  logic [IDX_W-1:0] wb_off;
  logic [31:0]      head_pc, branch_next_pc;

  assign full          = (count == DEPTH_CNT);
  assign rob.rob_full  = full || (state == FLUSH);
  assign rob.issue_tag = tail;

  assign do_dispatch = rdy_in && (state == RUN) && rob.issue_valid && !full;
  // Live entries occupy [head, head+count) modulo depth; others ignore writeback.
  assign wb_off      = rob.wb_tag - head;
  assign wb_hit      = rdy_in && (state == RUN) && rob.wb_valid && ({1'b0, wb_off} < count);
  assign do_retire   = rdy_in && (state == RUN) && (count != '0) && ready[head];

  assign head_pc        = pc_q[head];
  assign head_is_b      = (op_type_q[head] == OP_TYPE_B);
  assign head_taken     = value_q[head][0];
  assign mispredict     = head_is_b && (head_taken != pred_q[head]);
  assign branch_next_pc = head_taken ? head_pc + imm_q[head] : head_pc + 32'd4;

  // NOTE: the payload RAM has no reset; an entry is only read once dispatch and writeback have filled it.
  always_ff @(posedge clk_in) begin
    if (do_dispatch) begin
      pc_q[tail]      <= rob.issue_pc;
      op_q[tail]      <= rob.issue_op;
      op_type_q[tail] <= rob.issue_op_type;
      pred_q[tail]    <= rob.issue_pred;
      imm_q[tail]     <= rob.issue_imm;
      rd_q[tail]      <= rob.issue_rd;
    end
    if (wb_hit) begin
      value_q[rob.wb_tag]  <= rob.wb_value;
      target_q[rob.wb_tag] <= rob.wb_target;
    end
  end

  // NOTE: state uses non-blocking assignments so every read in this block sees pre-edge values.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state             <= RUN;
      head              <= '0;
      tail              <= '0;
      count             <= '0;
      ready             <= '0;
      rob.rob_commit    <= 1'b0;
      rob.roll_back     <= 1'b0;
      rob.rob_pc_commit <= '0;
      rob.rob_op_commit <= '0;
      rob.rob_op_type   <= '0;
      rob.rob_result    <= '0;
      rob.rob_pc_result <= '0;
      rob.commit_rd     <= '0;
      rob.commit_value  <= '0;
    end else if (rdy_in) begin
      rob.rob_commit <= 1'b0;
      rob.roll_back  <= 1'b0;
      if (state == FLUSH) begin
        state <= RUN;
      end else begin
        if (do_retire) begin
          rob.rob_pc_commit <= head_pc;
          rob.rob_op_commit <= op_q[head];
          rob.rob_op_type   <= op_type_q[head];
          rob.commit_value  <= value_q[head];
          if (head_is_b) begin
            rob.rob_commit    <= !mispredict;
            rob.roll_back     <= mispredict;
            rob.rob_result    <= {31'd0, head_taken};
            rob.rob_pc_result <= branch_next_pc;
            rob.commit_rd     <= '0;
          end else begin
            rob.rob_commit    <= 1'b1;
            rob.rob_result    <= '0;
            rob.rob_pc_result <= (op_q[head] == OP_JALR) ? target_q[head] : head_pc + 32'd4;
            rob.commit_rd     <= rd_q[head];
          end
        end
        // A misprediction discards everything, including a same-cycle dispatch.
        if (do_retire && mispredict) begin
          head  <= '0;
          tail  <= '0;
          count <= '0;
          ready <= '0;
          state <= FLUSH;
        end else begin
          if (do_dispatch) begin
            tail        <= tail + IDX_W'(1);
            ready[tail] <= 1'b0;
          end
          if (wb_hit) ready[rob.wb_tag] <= 1'b1;
          if (do_retire) head <= head + IDX_W'(1);
          count <= count + (IDX_W+1)'(do_dispatch) - (IDX_W+1)'(do_retire);
        end
      end
    end else begin
      rob.rob_commit <= 1'b0;
      rob.roll_back  <= 1'b0;
    end
  end

`ifdef ROB_STATS_EN
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      stat_commits     <= '0;
      stat_mispredicts <= '0;
    end else if (do_retire) begin
      if (mispredict) stat_mispredicts <= stat_mispredicts + 32'd1;
      else            stat_commits     <= stat_commits + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_reorder_buffer_commit.sv
// Self-checking bench for reorder_buffer_commit: per-cycle vector table plus
// hand-written full/wrap, rdy stall and mid-operation reset sequences.
module tb_reorder_buffer_commit;
  localparam int DEPTH = 16;
  localparam int IDX_W = 4;
  localparam logic [5:0] OP_ADD  = 6'd10;
  localparam logic [5:0] OP_JALR = 6'd3;
  localparam logic [5:0] OP_BEQ  = 6'd4;
  localparam logic [2:0] T_R = 3'd0;
  localparam logic [2:0] T_I = 3'd1;
  localparam logic [2:0] T_B = 3'd3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rdy = 1'b1;
  always #5 clk = ~clk;

  reorder_buffer_commit_if #(.IDX_W(IDX_W)) bus ();

`ifdef ROB_STATS_EN
  logic [31:0] stat_commits, stat_mispredicts;
`endif

  reorder_buffer_commit #(.ROB_DEPTH(DEPTH), .IDX_W(IDX_W), .OP_JALR(OP_JALR), .OP_TYPE_B(T_B)) dut (
    .clk_in (clk),
    .rst_in (rst_n),
    .rdy_in (rdy),
    .rob    (bus)
`ifdef ROB_STATS_EN
    ,
    .stat_commits     (stat_commits),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  typedef struct {
    logic        iv;
    logic [31:0] pc;
    logic [5:0]  op;
    logic [2:0]  ot;
    logic        pred;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        wv;
    logic [3:0]  wt;
    logic [31:0] wval;
    logic [31:0] wtgt;
    logic        e_commit;
    logic        e_roll;
    logic        e_full;
    logic [3:0]  e_tag;
    logic        cd;
    logic [31:0] e_pc;
    logic [4:0]  e_rd;
    logic [5:0]  e_op;
    logic [2:0]  e_ot;
    logic        cv;
    logic [31:0] e_val;
    logic        cr;
    logic [31:0] e_res;
    logic        cp;
    logic [31:0] e_pcr;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t idle_v();
    vec_t v;
    v.iv = 1'b0; v.pc = '0; v.op = '0; v.ot = '0; v.pred = 1'b0; v.imm = '0; v.rd = '0;
    v.wv = 1'b0; v.wt = '0; v.wval = '0; v.wtgt = '0;
    v.e_commit = 1'b0; v.e_roll = 1'b0; v.e_full = 1'b0; v.e_tag = '0;
    v.cd = 1'b0; v.e_pc = '0; v.e_rd = '0; v.e_op = '0; v.e_ot = '0;
    v.cv = 1'b0; v.e_val = '0; v.cr = 1'b0; v.e_res = '0; v.cp = 1'b0; v.e_pcr = '0;
    return v;
  endfunction

  function automatic vec_t disp_v(input logic [31:0] pc, input logic [5:0] op, input logic [2:0] ot,
                                  input logic pred, input logic [31:0] imm, input logic [4:0] rd);
    vec_t v = idle_v();
    v.iv = 1'b1; v.pc = pc; v.op = op; v.ot = ot; v.pred = pred; v.imm = imm; v.rd = rd;
    return v;
  endfunction

  function automatic vec_t wb_v(input logic [3:0] tag, input logic [31:0] val, input logic [31:0] tgt);
    vec_t v = idle_v();
    v.wv = 1'b1; v.wt = tag; v.wval = val; v.wtgt = tgt;
    return v;
  endfunction

  function automatic vec_t ex(input vec_t v_in, input logic c, input logic r, input logic f, input logic [3:0] tag);
    vec_t v = v_in;
    v.e_commit = c; v.e_roll = r; v.e_full = f; v.e_tag = tag;
    return v;
  endfunction

  function automatic vec_t prd(input vec_t v_in, input logic [31:0] pc, input logic [4:0] rd,
                               input logic [5:0] op, input logic [2:0] ot);
    vec_t v = v_in;
    v.cd = 1'b1; v.e_pc = pc; v.e_rd = rd; v.e_op = op; v.e_ot = ot;
    return v;
  endfunction

  function automatic vec_t val(input vec_t v_in, input logic [31:0] x);
    vec_t v = v_in;
    v.cv = 1'b1; v.e_val = x;
    return v;
  endfunction

  function automatic vec_t res(input vec_t v_in, input logic [31:0] x);
    vec_t v = v_in;
    v.cr = 1'b1; v.e_res = x;
    return v;
  endfunction

  function automatic vec_t pcr(input vec_t v_in, input logic [31:0] x);
    vec_t v = v_in;
    v.cp = 1'b1; v.e_pcr = x;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    bus.issue_valid   = v.iv;
    bus.issue_pc      = v.pc;
    bus.issue_op      = v.op;
    bus.issue_op_type = v.ot;
    bus.issue_pred    = v.pred;
    bus.issue_imm     = v.imm;
    bus.issue_rd      = v.rd;
    bus.wb_valid      = v.wv;
    bus.wb_tag        = v.wt;
    bus.wb_value      = v.wval;
    bus.wb_target     = v.wtgt;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1);
  end

  vec_t        vecs[$];
  vec_t        v;
  int          order[16];
  logic [31:0] sb_pc[17];
  logic [31:0] sb_val[17];
  logic [4:0]  sb_rd[17];
  int          n_ret;

  initial begin
    drive(idle_v());
    repeat (2) @(negedge clk);
    check("rst_commit",    32'(bus.rob_commit), 32'd0);
    check("rst_roll",      32'(bus.roll_back), 32'd0);
    check("rst_pc_commit", bus.rob_pc_commit, 32'd0);
    check("rst_op",        32'(bus.rob_op_commit), 32'd0);
    check("rst_op_type",   32'(bus.rob_op_type), 32'd0);
    check("rst_result",    bus.rob_result, 32'd0);
    check("rst_pc_result", bus.rob_pc_result, 32'd0);
    check("rst_rd",        32'(bus.commit_rd), 32'd0);
    check("rst_value",     bus.commit_value, 32'd0);
    check("rst_full",      32'(bus.rob_full), 32'd0);
    check("rst_tag",       32'(bus.issue_tag), 32'd0);
    rst_n = 1'b1;

    // ALU op, mispredicted branch with younger entry, JALR, correct branch, not-taken mispredict
    vecs.push_back(ex(disp_v(32'h100, OP_ADD, T_R, 1'b0, 32'd0, 5'd5), 1'b0, 1'b0, 1'b0, 4'd1));
    vecs.push_back(ex(wb_v(4'd0, 32'h2A, 32'd0), 1'b0, 1'b0, 1'b0, 4'd1));
    vecs.push_back(val(prd(ex(idle_v(), 1'b1, 1'b0, 1'b0, 4'd1), 32'h100, 5'd5, OP_ADD, T_R), 32'h2A));
    vecs.push_back(ex(idle_v(), 1'b0, 1'b0, 1'b0, 4'd1));
    vecs.push_back(ex(disp_v(32'h200, OP_BEQ, T_B, 1'b0, 32'h40, 5'd0), 1'b0, 1'b0, 1'b0, 4'd2));
    vecs.push_back(ex(disp_v(32'h204, OP_ADD, T_R, 1'b0, 32'd0, 5'd7), 1'b0, 1'b0, 1'b0, 4'd3));
    vecs.push_back(ex(wb_v(4'd2, 32'h55, 32'd0), 1'b0, 1'b0, 1'b0, 4'd3));
    vecs.push_back(ex(wb_v(4'd1, 32'h1, 32'd0), 1'b0, 1'b0, 1'b0, 4'd3));
    vecs.push_back(pcr(res(prd(ex(disp_v(32'h208, OP_ADD, T_R, 1'b0, 32'd0, 5'd9), 1'b0, 1'b1, 1'b1, 4'd0),
                               32'h200, 5'd0, OP_BEQ, T_B), 32'd1), 32'h240));
    vecs.push_back(ex(idle_v(), 1'b0, 1'b0, 1'b0, 4'd0));
    vecs.push_back(ex(idle_v(), 1'b0, 1'b0, 1'b0, 4'd0));
    vecs.push_back(ex(disp_v(32'h300, OP_JALR, T_I, 1'b0, 32'd0, 5'd1), 1'b0, 1'b0, 1'b0, 4'd1));
    vecs.push_back(ex(wb_v(4'd0, 32'h304, 32'h1000), 1'b0, 1'b0, 1'b0, 4'd1));
    vecs.push_back(pcr(val(prd(ex(idle_v(), 1'b1, 1'b0, 1'b0, 4'd1), 32'h300, 5'd1, OP_JALR, T_I), 32'h304), 32'h1000));
    vecs.push_back(ex(disp_v(32'h400, OP_BEQ, T_B, 1'b1, 32'h20, 5'd0), 1'b0, 1'b0, 1'b0, 4'd2));
    vecs.push_back(ex(wb_v(4'd1, 32'h1, 32'd0), 1'b0, 1'b0, 1'b0, 4'd2));
    vecs.push_back(res(prd(ex(idle_v(), 1'b1, 1'b0, 1'b0, 4'd2), 32'h400, 5'd0, OP_BEQ, T_B), 32'd1));
    vecs.push_back(ex(disp_v(32'h500, OP_BEQ, T_B, 1'b1, 32'h80, 5'd0), 1'b0, 1'b0, 1'b0, 4'd3));
    vecs.push_back(ex(wb_v(4'd2, 32'h0, 32'd0), 1'b0, 1'b0, 1'b0, 4'd3));
    vecs.push_back(pcr(res(prd(ex(idle_v(), 1'b0, 1'b1, 1'b1, 4'd0), 32'h500, 5'd0, OP_BEQ, T_B), 32'd0), 32'h504));
    vecs.push_back(ex(idle_v(), 1'b0, 1'b0, 1'b0, 4'd0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      step();
      check($sformatf("v%0d_commit", i), 32'(bus.rob_commit), 32'(vecs[i].e_commit));
      check($sformatf("v%0d_roll", i),   32'(bus.roll_back),  32'(vecs[i].e_roll));
      check($sformatf("v%0d_full", i),   32'(bus.rob_full),   32'(vecs[i].e_full));
      check($sformatf("v%0d_tag", i),    32'(bus.issue_tag),  32'(vecs[i].e_tag));
      if (vecs[i].cd) begin
        check($sformatf("v%0d_pc_commit", i), bus.rob_pc_commit, vecs[i].e_pc);
        check($sformatf("v%0d_rd", i),        32'(bus.commit_rd), 32'(vecs[i].e_rd));
        check($sformatf("v%0d_op", i),        32'(bus.rob_op_commit), 32'(vecs[i].e_op));
        check($sformatf("v%0d_op_type", i),   32'(bus.rob_op_type), 32'(vecs[i].e_ot));
      end
      if (vecs[i].cv) check($sformatf("v%0d_value", i), bus.commit_value, vecs[i].e_val);
      if (vecs[i].cr) check($sformatf("v%0d_result", i), bus.rob_result, vecs[i].e_res);
      if (vecs[i].cp) check($sformatf("v%0d_pc_result", i), bus.rob_pc_result, vecs[i].e_pcr);
    end

    // Fill all 16 entries from head=tail=0; tail wraps back to 0 and the buffer reports full.
    for (int i = 0; i < DEPTH; i++) begin
      drive(disp_v(32'h1000 + 32'(4 * i), OP_ADD, T_R, 1'b0, 32'd0, 5'(i + 1)));
      step();
      check("fill_tag", 32'(bus.issue_tag), 32'((i + 1) % DEPTH));
      check("fill_full", 32'(bus.rob_full), (i == DEPTH - 1) ? 32'd1 : 32'd0);
      sb_pc[i]  = 32'h1000 + 32'(4 * i);
      sb_val[i] = 32'hA000 + 32'(i);
      sb_rd[i]  = 5'(i + 1);
    end
    sb_pc[16] = 32'h2000; sb_val[16] = 32'hB000; sb_rd[16] = 5'd20;
    drive(disp_v(32'hDEAD, OP_ADD, T_R, 1'b0, 32'd0, 5'd31));
    step();
    check("overflow_tag", 32'(bus.issue_tag), 32'd0);
    check("overflow_full", 32'(bus.rob_full), 32'd1);

    // Out-of-order completion (tag 3 first); a dispatch held high while full is rejected
    // even in the cycle a retire frees a slot; the next dispatch overlaps a retire.
    order = '{3, 0, 1, 2, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15};
    n_ret = 0;
    for (int k = 0; k < 40 && n_ret < 17; k++) begin
      v = idle_v();
      if (k <= 2) begin
        v.iv = 1'b1; v.pc = 32'hDEAD; v.op = OP_ADD; v.rd = 5'd31;
      end else if (k == 3) begin
        v.iv = 1'b1; v.pc = 32'h2000; v.op = OP_ADD; v.rd = 5'd20;
      end
      if (k < 16) begin
        v.wv = 1'b1; v.wt = 4'(order[k]); v.wval = 32'hA000 + 32'(order[k]);
      end else if (k == 16) begin
        v.wv = 1'b1; v.wt = 4'd0; v.wval = 32'hB000;
      end
      drive(v);
      step();
      if (k == 2) check("full_reject_tag", 32'(bus.issue_tag), 32'd0);
      if (k == 3) begin
        check("disp_retire_tag", 32'(bus.issue_tag), 32'd1);
        check("disp_retire_full", 32'(bus.rob_full), 32'd0);
      end
      check("wrap_roll", 32'(bus.roll_back), 32'd0);
      if (bus.rob_commit) begin
        if (n_ret < 17) begin
          check($sformatf("wrap%0d_pc", n_ret), bus.rob_pc_commit, sb_pc[n_ret]);
          check($sformatf("wrap%0d_value", n_ret), bus.commit_value, sb_val[n_ret]);
          check($sformatf("wrap%0d_rd", n_ret), 32'(bus.commit_rd), 32'(sb_rd[n_ret]));
        end
        n_ret++;
      end
    end
    check("wrap_retired", 32'(n_ret), 32'd17);
    drive(idle_v());
    repeat (3) begin
      step();
      check("no_extra_commit", 32'(bus.rob_commit), 32'd0);
    end
    check("wrap_end_tag", 32'(bus.issue_tag), 32'd1);
    check("wrap_end_full", 32'(bus.rob_full), 32'd0);

    // rdy low for 3 cycles with a ready head: nothing moves, data outputs hold.
    drive(disp_v(32'h600, OP_ADD, T_R, 1'b0, 32'd0, 5'd3));
    step();
    check("rdy_disp_tag", 32'(bus.issue_tag), 32'd2);
    drive(wb_v(4'd1, 32'h77, 32'd0));
    step();
    check("rdy_wb_commit", 32'(bus.rob_commit), 32'd0);
    rdy = 1'b0;
    drive(disp_v(32'h700, OP_ADD, T_R, 1'b0, 32'd0, 5'd6));
    repeat (3) begin
      step();
      check("stall_commit", 32'(bus.rob_commit), 32'd0);
      check("stall_roll", 32'(bus.roll_back), 32'd0);
      check("stall_tag", 32'(bus.issue_tag), 32'd2);
      check("stall_pc_hold", bus.rob_pc_commit, 32'h2000);
    end
    rdy = 1'b1;
    drive(idle_v());
    step();
    check("resume_commit", 32'(bus.rob_commit), 32'd1);
    check("resume_pc", bus.rob_pc_commit, 32'h600);
    check("resume_value", bus.commit_value, 32'h77);
    check("resume_rd", 32'(bus.commit_rd), 32'd3);
    step();
    check("resume_pulse_end", 32'(bus.rob_commit), 32'd0);

    // Asynchronous reset while a commit pulse is showing.
    drive(disp_v(32'h800, OP_ADD, T_R, 1'b0, 32'd0, 5'd4));
    step();
    drive(wb_v(4'd2, 32'h99, 32'd0));
    step();
    drive(idle_v());
    step();
    check("pre_reset_commit", 32'(bus.rob_commit), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_commit", 32'(bus.rob_commit), 32'd0);
    check("async_rst_pc", bus.rob_pc_commit, 32'd0);
    check("async_rst_value", bus.commit_value, 32'd0);
    check("async_rst_rd", 32'(bus.commit_rd), 32'd0);
    check("async_rst_tag", 32'(bus.issue_tag), 32'd0);
    check("async_rst_full", 32'(bus.rob_full), 32'd0);
`ifdef ROB_STATS_EN
    check("async_rst_stat_commits", stat_commits, 32'd0);
    check("async_rst_stat_mispredicts", stat_mispredicts, 32'd0);
`endif
    #1 rst_n = 1'b1;
    step();
    check("post_reset_commit", 32'(bus.rob_commit), 32'd0);
    check("post_reset_tag", 32'(bus.issue_tag), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
